// File: rtl/dds_wave_synth.sv
// Single-clock DDS waveform synth: phase accumulator with octave shift, quarter-wave sine,
// triangle, square and saw outputs, debounced waveform select applied only at a phase wrap.
module dds_wave_synth #(
  parameter int PHASE_W   = 24,
  parameter int TUNE_W    = 16,
  parameter int OUT_W     = 8,
  parameter int LUT_AW    = 6,
  parameter int DB_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [TUNE_W-1:0] tune,
  input  logic [1:0]        octave,
  input  logic              sel,
  output logic [OUT_W-1:0]  wav,
  output logic [1:0]        wave_id,
  output logic              cycle_start
);

  localparam int TOP_W = (OUT_W + 1 > LUT_AW + 2) ? OUT_W + 1 : LUT_AW + 2;
  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [OUT_W-1:0] MID     = {1'b1, {(OUT_W-1){1'b0}}};

  // Elaboration-time sine table entry: round((2^(OUT_W-1)-1) * sin(pi/2 * (k+0.5) / 2^LUT_AW))
  function automatic int sine_q(input int k);
    real x;
    real term;
    real s;
    x    = 1.5707963267948966 * (real'(k) + 0.5) / (2.0 ** LUT_AW);
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return $rtoi(s * ((2.0 ** (OUT_W - 1)) - 1.0) + 0.5);
  endfunction

  logic [OUT_W-1:0] sine_lut [2**LUT_AW];
  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_lut
    localparam int QV = sine_q(k);
    assign sine_lut[k] = OUT_W'(QV);
  end

  logic [PHASE_W-1:0] phase;
  logic               carry;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W:0]   sum;
  logic               wrap;

  assign inc  = {{(PHASE_W-TUNE_W){1'b0}}, tune} << octave;
  assign sum  = {1'b0, phase} + {1'b0, inc};
  assign wrap = en & sum[PHASE_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
      carry <= 1'b0;
    end else if (en) begin
      {carry, phase} <= sum;
    end else begin
      carry <= 1'b0;
    end
  end

  logic             sel_s1;
  logic             sel_s2;
  logic             sel_stable;
  logic [CNT_W-1:0] db_cnt;
  logic             press;

  assign press = (sel_s2 != sel_stable) && (db_cnt == DB_LAST) && sel_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_s1     <= 1'b0;
      sel_s2     <= 1'b0;
      sel_stable <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sel_s1 <= sel;
      sel_s2 <= sel_s1;
      if (sel_s2 == sel_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt     <= '0;
        sel_stable <= sel_s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  logic [1:0] pending_sel;
  logic [1:0] active_sel;

  // With no audio playing (frozen or zero increment) the switch cannot glitch, so apply at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_sel <= 2'd0;
      active_sel  <= 2'd0;
    end else begin
      pending_sel <= pending_sel + 2'(press);
      if (!en || (inc == '0) || wrap)
        active_sel <= pending_sel;
    end
  end

  assign wave_id = active_sel;

  // ---- stage 1: capture phase top bits, waveform and wrap flag ----
  logic [TOP_W-1:0] top_p1;
  logic [1:0]       sel_p1;
  logic             carry_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_p1   <= '0;
      sel_p1   <= 2'd0;
      carry_p1 <= 1'b0;
    end else begin
      top_p1   <= phase[PHASE_W-1 -: TOP_W];
      sel_p1   <= active_sel;
      carry_p1 <= carry;
    end
  end

  logic [1:0]        quad_p1;
  logic [LUT_AW-1:0] idx_p1;
  logic [LUT_AW-1:0] lut_addr_p1;
  logic [OUT_W-1:0]  q_p1;
  logic [OUT_W-1:0]  tri_r_p1;
  logic [OUT_W-1:0]  sample_p1;

  assign quad_p1     = top_p1[TOP_W-1 -: 2];
  assign idx_p1      = top_p1[TOP_W-3 -: LUT_AW];
  assign lut_addr_p1 = quad_p1[0] ? ~idx_p1 : idx_p1;
  assign q_p1        = sine_lut[lut_addr_p1];
  assign tri_r_p1    = top_p1[TOP_W-2 -: OUT_W];

  always_comb begin
    sample_p1 = MID;
    case (sel_p1)
      2'd0:    sample_p1 = quad_p1[1] ? (MID - 1'b1 - q_p1) : (MID + q_p1);
      2'd1:    sample_p1 = top_p1[TOP_W-1] ? ~tri_r_p1 : tri_r_p1;
      2'd2:    sample_p1 = top_p1[TOP_W-1] ? '0 : '1;
      default: sample_p1 = top_p1[TOP_W-1 -: OUT_W];
    endcase
  end

  // ---- stage 2: registered DAC sample and period strobe ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wav         <= MID;
      cycle_start <= 1'b0;
    end else begin
      wav         <= sample_p1;
      cycle_start <= carry_p1;
    end
  end

endmodule

// File: tb/tb_dds_wave_synth.sv
// Directed bench for dds_wave_synth: reset, period timing, waveform shapes, debounce and
// wrap-aligned waveform switching, with hand-computed expected samples.
module tb_dds_wave_synth;

  localparam int DB = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] tune;
  logic [1:0]  octave;
  logic        sel;
  logic [7:0]  wav;
  logic [1:0]  wave_id;
  logic        cycle_start;

  int errors = 0;
  int checks = 0;

  dds_wave_synth #(
    .PHASE_W(24), .TUNE_W(16), .OUT_W(8), .LUT_AW(6), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tune(tune), .octave(octave), .sel(sel),
    .wav(wav), .wave_id(wave_id), .cycle_start(cycle_start)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Negedges until cycle_start is seen; -1 if the budget runs out
  task automatic wait_cs(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (cycle_start === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic press(input int hi, input int lo);
    sel = 1'b1;
    step(hi);
    sel = 1'b0;
    step(lo);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tune = 16'h0; octave = 2'd0; sel = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (wav !== 8'd128) begin errors++; $display("FAIL reset_wav: got %0d expected 128", wav); end
    checks++; if (wave_id !== 2'd0) begin errors++; $display("FAIL reset_wave_id: got %0d expected 0", wave_id); end
    checks++; if (cycle_start !== 1'b0) begin errors++; $display("FAIL reset_cs: got %0b expected 0", cycle_start); end
    step(3);
    rst = 1'b1;
    step(3);
    checks++; if (wav !== 8'd130) begin errors++; $display("FAIL release_wav: got %0d expected 130", wav); end
    checks++; if (wave_id !== 2'd0) begin errors++; $display("FAIL release_wave_id: got %0d expected 0", wave_id); end
    checks++; if (cycle_start !== 1'b0) begin errors++; $display("FAIL release_cs: got %0b expected 0", cycle_start); end
  endtask

  task automatic test_frequency();
    int c;
    int total;
    int bad;
    tune = 16'h1000; octave = 2'd0; en = 1'b1;
    wait_cs(10000, c);
    checks++; if (c != 4098) begin errors++; $display("FAIL first_wrap: got %0d expected 4098", c); end
    wait_cs(5000, c);
    checks++; if (c != 4096) begin errors++; $display("FAIL period_oct0: got %0d expected 4096", c); end
    octave = 2'd2;
    wait_cs(2000, c);
    wait_cs(2000, c);
    checks++; if (c != 1024) begin errors++; $display("FAIL period_oct2: got %0d expected 1024", c); end
    octave = 2'd3; tune = 16'hFFFF;
    wait_cs(2000, c);
    total = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      wait_cs(100, c);
      if (c < 32 || c > 33) bad++;
      total += c;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL period_oct3_each: got %0d bad periods expected 0", bad); end
    checks++; if (total < 3200 || total > 3201) begin errors++; $display("FAIL period_oct3_total: got %0d expected 3200..3201", total); end
  endtask

  task automatic test_reset_midrun();
    step(1);
    #2 rst = 1'b0;
    #1;
    checks++; if (wav !== 8'd128) begin errors++; $display("FAIL midrun_reset_wav: got %0d expected 128", wav); end
    checks++; if (cycle_start !== 1'b0) begin errors++; $display("FAIL midrun_reset_cs: got %0b expected 0", cycle_start); end
    en = 1'b0; tune = 16'h1000; octave = 2'd0;
    step(2);
    rst = 1'b1;
    step(3);
    checks++; if (wav !== 8'd130) begin errors++; $display("FAIL midrun_release_wav: got %0d expected 130", wav); end
  endtask

  task automatic test_glitch_free_switch();
    int c;
    int wid_at;
    int cs_at;
    logic [7:0] prev;
    en = 1'b1;
    wait_cs(5000, c);
    checks++; if (c != 4098) begin errors++; $display("FAIL realigned_wrap: got %0d expected 4098", c); end
    press(DB + 10, DB + 10);
    checks++; if (wave_id !== 2'd0) begin errors++; $display("FAIL switch_early: got %0d expected 0", wave_id); end
    wid_at = -1; cs_at = -1; prev = wav;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (wave_id === 2'd1 && wid_at < 0) wid_at = i;
      if (cycle_start === 1'b1) begin
        cs_at = i;
        break;
      end
      prev = wav;
    end
    checks++; if (cs_at < 0 || cs_at - wid_at != 2) begin errors++; $display("FAIL switch_align: got id@%0d cs@%0d expected id 2 before cs", wid_at, cs_at); end
    checks++; if (prev !== 8'd125) begin errors++; $display("FAIL last_sine_sample: got %0d expected 125", prev); end
    checks++; if (wav !== 8'd0) begin errors++; $display("FAIL first_tri_sample: got %0d expected 0", wav); end
    checks++; if (wave_id !== 2'd1) begin errors++; $display("FAIL switch_wave_id: got %0d expected 1", wave_id); end
  endtask

  task automatic test_triangle();
    step(8);
    checks++; if (wav !== 8'd1) begin errors++; $display("FAIL tri_n8: got %0d expected 1", wav); end
    step(2039);
    checks++; if (wav !== 8'd255) begin errors++; $display("FAIL tri_n2047: got %0d expected 255", wav); end
    step(1);
    checks++; if (wav !== 8'd255) begin errors++; $display("FAIL tri_n2048: got %0d expected 255", wav); end
    step(2047);
    checks++; if (wav !== 8'd0) begin errors++; $display("FAIL tri_n4095: got %0d expected 0", wav); end
  endtask

  task automatic test_frozen_press();
    int c;
    int lat;
    wait_cs(10, c);
    checks++; if (c != 1) begin errors++; $display("FAIL tri_wrap: got %0d expected 1", c); end
    en = 1'b0;
    step(3);
    checks++; if (wav !== 8'd0) begin errors++; $display("FAIL frozen_tri: got %0d expected 0", wav); end
    step(10);
    checks++; if (wav !== 8'd0) begin errors++; $display("FAIL frozen_hold: got %0d expected 0", wav); end
    sel = 1'b1;
    lat = -1;
    for (int i = 1; i <= DB + 10; i++) begin
      @(negedge clk);
      if (wave_id === 2'd2) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat < DB || lat > DB + 4) begin errors++; $display("FAIL frozen_latency: got %0d expected %0d..%0d", lat, DB, DB + 4); end
    step(3);
    checks++; if (wav !== 8'd255) begin errors++; $display("FAIL frozen_square: got %0d expected 255", wav); end
    step(10);
    checks++; if (wav !== 8'd255) begin errors++; $display("FAIL frozen_square_hold: got %0d expected 255", wav); end
    sel = 1'b0;
    step(DB + 10);
    checks++; if (wave_id !== 2'd2) begin errors++; $display("FAIL release_no_inc: got %0d expected 2", wave_id); end
  endtask

  task automatic test_square();
    int c;
    en = 1'b1;
    wait_cs(5000, c);
    checks++; if (c != 4096) begin errors++; $display("FAIL sq_wrap: got %0d expected 4096", c); end
    checks++; if (wav !== 8'd255) begin errors++; $display("FAIL sq_n0: got %0d expected 255", wav); end
    step(2047);
    checks++; if (wav !== 8'd255) begin errors++; $display("FAIL sq_n2047: got %0d expected 255", wav); end
    step(1);
    checks++; if (wav !== 8'd0) begin errors++; $display("FAIL sq_n2048: got %0d expected 0", wav); end
    step(2047);
    checks++; if (wav !== 8'd0) begin errors++; $display("FAIL sq_n4095: got %0d expected 0", wav); end
  endtask

  task automatic test_debounce();
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sel = (i % 2 == 0);
      step(100);
    end
    sel = 1'b0;
    checks++; if (wave_id !== 2'd2) begin errors++; $display("FAIL bounce_no_inc: got %0d expected 2", wave_id); end
    sel = 1'b1;
    step(DB + 50);
    checks++; if (wave_id !== 2'd3) begin errors++; $display("FAIL bounce_then_stable: got %0d expected 3", wave_id); end
    sel = 1'b0;
    step(DB + 50);
    checks++; if (wave_id !== 2'd3) begin errors++; $display("FAIL release_hold: got %0d expected 3", wave_id); end
    sel = 1'b1;
    step(DB - 50);
    sel = 1'b0;
    step(DB + 50);
    checks++; if (wave_id !== 2'd3) begin errors++; $display("FAIL short_pulse: got %0d expected 3", wave_id); end
  endtask

  task automatic test_saw();
    int c;
    en = 1'b1;
    wait_cs(5000, c);
    checks++; if (wav !== 8'd0) begin errors++; $display("FAIL saw_n0: got %0d expected 0", wav); end
    step(15);
    checks++; if (wav !== 8'd0) begin errors++; $display("FAIL saw_n15: got %0d expected 0", wav); end
    step(1);
    checks++; if (wav !== 8'd1) begin errors++; $display("FAIL saw_n16: got %0d expected 1", wav); end
    step(4079);
    checks++; if (wav !== 8'd255) begin errors++; $display("FAIL saw_n4095: got %0d expected 255", wav); end
    step(1);
    checks++; if (cycle_start !== 1'b1 || wav !== 8'd0) begin errors++; $display("FAIL saw_wrap: got cs=%0b wav=%0d expected cs=1 wav=0", cycle_start, wav); end
  endtask

  task automatic test_back_to_back_presses();
    int c;
    press(DB + 10, DB + 10);
    press(DB + 10, DB + 10);
    press(DB + 10, DB + 10);
    checks++; if (wave_id !== 2'd3) begin errors++; $display("FAIL presses_held: got %0d expected 3", wave_id); end
    wait_cs(5000, c);
    checks++; if (c < 0 || wave_id !== 2'd2) begin errors++; $display("FAIL presses_applied: got %0d expected 2", wave_id); end
    checks++; if (wav !== 8'd255) begin errors++; $display("FAIL presses_first_sq: got %0d expected 255", wav); end
  endtask

  task automatic test_tune_zero();
    int lat;
    tune = 16'h0;
    step(3);
    checks++; if (wav !== 8'd255) begin errors++; $display("FAIL tune0_square: got %0d expected 255", wav); end
    sel = 1'b1;
    lat = -1;
    for (int i = 1; i <= DB + 10; i++) begin
      @(negedge clk);
      if (wave_id === 2'd3) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat < DB || lat > DB + 4) begin errors++; $display("FAIL tune0_latency: got %0d expected %0d..%0d", lat, DB, DB + 4); end
    step(3);
    checks++; if (wav !== 8'd0) begin errors++; $display("FAIL tune0_saw: got %0d expected 0", wav); end
    sel = 1'b0;
    step(DB + 10);
  endtask

  initial begin
    test_reset();
    test_frequency();
    test_reset_midrun();
    test_glitch_free_switch();
    test_triangle();
    test_frozen_press();
    test_square();
    test_debounce();
    test_saw();
    test_back_to_back_presses();
    test_tune_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
